auction_round_sequencer: RTL and testbench
==========================================

AUCTION_ROUND_SEQUENCER -- requirements
Module: auction_round_sequencer

Interface
REQ-001 The block SHALL have these parameters, one per line:
- DATAWIDTH, 32, width of key, balances, mask, timer, charge and maxBid
- RLENW, 16, width of round_len
- TIMEOUT, 255, maximum wait cycles in WAIT_READY and in WAIT_OVER
REQ-002 The block SHALL have these ports, one per line:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- go  in  1  host request to configure the auction unit and run one round
- cfg_key, cfg_x, cfg_y, cfg_z, cfg_mask, cfg_timer, cfg_charge  in  DATAWIDTH each  host configuration
- round_len  in  RLENW  number of cycles C_start is held high
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- status  out  3  0=OK, 1=CFG_ERR, 2=READY_TIMEOUT, 3=OVER_TIMEOUT
- result  out  DATAWIDTH  maxBid captured at round end
- C_op  out  4  opcode to auction unit: NO_OP=0, UNLOCK=1, LOCK=2, LOADX=3, LOADY=4, LOADZ=5, SETMASK=6, SETTIMER=7, SETBIDCHARGE=8
- C_data  out  DATAWIDTH  operand to auction unit
- C_start  out  1  round-start level to auction unit
- ready  in  1  auction unit locked and ready
- err  in  4  auction unit controller error, 0 = none
- roundOver  in  1  auction unit round finished
- maxBid  in  DATAWIDTH  winning bid from auction unit

Function
REQ-003 The FSM SHALL have states IDLE, UNLK, LDX, LDY, LDZ, MASK, TMR, CHG, LOCK, WAIT_READY, RUN, WAIT_OVER, FIN.
REQ-004 In IDLE with go=1, the block SHALL register all cfg_* inputs and round_len, and SHALL enter UNLK on the next edge.
REQ-005 go SHALL be ignored in every state except IDLE.
REQ-006 UNLK through LOCK SHALL each last exactly one cycle, in order, and SHALL drive C_op and C_data as follows:
- UNLK: UNLOCK / key
- LDX: LOADX / x
- LDY: LOADY / y
- LDZ: LOADZ / z
- MASK: SETMASK / mask
- TMR: SETTIMER / timer
- CHG: SETBIDCHARGE / charge
- LOCK: LOCK / key
REQ-007 In every other state, C_op SHALL be NO_OP and C_data SHALL be 0.
REQ-008 In any state UNLK..LOCK, if err!=0 in that cycle, the block SHALL latch status=1 and go to FIN instead of the next state.
REQ-009 WAIT_READY SHALL go to RUN when ready=1.
REQ-010 WAIT_READY SHALL latch status=2 and go to FIN after TIMEOUT consecutive cycles with ready=0.
REQ-011 In RUN, C_start SHALL be 1 for exactly max(round_len,1) cycles, counted by an RLENW-bit down counter; the block SHALL then go to WAIT_OVER.
REQ-012 In WAIT_OVER, C_start SHALL be 0; on roundOver=1 the block SHALL capture maxBid into result, set status=0 and go to FIN.
REQ-013 WAIT_OVER SHALL latch status=3 and go to FIN after TIMEOUT consecutive cycles with roundOver=0.
REQ-014 The wait counter SHALL clear on entry to each wait state and SHALL saturate; it SHALL never wrap.
REQ-015 FIN SHALL assert done for one cycle and SHALL return to IDLE.
REQ-016 status and result SHALL hold their values until the next go is accepted; on go acceptance status SHALL clear to 0.
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 If roundOver=1 while in RUN, it SHALL be ignored; only WAIT_OVER samples it.
REQ-019 If err!=0 and ready=1 in the same cycle, ready SHALL take effect only in WAIT_READY; err SHALL be sampled only in UNLK..LOCK.
REQ-020 All outputs SHALL be registered or decoded directly from state; there SHALL be no combinational path from ready, err or roundOver to C_op, C_data or C_start.

Reset
REQ-021 While reset=1, asynchronously, the block SHALL be in state IDLE.
REQ-022 While reset=1, outputs SHALL be: C_op=NO_OP, C_data=0, C_start=0, busy=0, done=0, status=0, result=0.
REQ-023 While reset=1, all counters and configuration registers SHALL be 0.
REQ-024 Reset asserted mid-sequence, including in RUN, SHALL drop C_start immediately and SHALL generate no done pulse.

Verification
REQ-025 Nominal run: key=0xA5, x=100, y=50, z=20, mask=3'b111, timer=0xF, charge=1, round_len=4; ready after 2 cycles, roundOver 3 cycles after C_start falls, maxBid=42 -> C_op sequence 1,3,4,5,6,7,8,2 on consecutive cycles; C_start high exactly 4 cycles; done pulse; status=0; result=42.
REQ-026 Config error: err=4'h3 while in LDY -> no LDZ..LOCK ops issued; done in the following cycle; status=1; C_start never asserted.
REQ-027 Ready timeout: TIMEOUT=8, ready held 0 -> done exactly 8 cycles after entering WAIT_READY; status=2.
REQ-028 Over timeout: roundOver held 0 -> status=3 after TIMEOUT cycles; result unchanged from the previous run.
REQ-029 Edge cases: round_len=0 gives C_start high for 1 cycle; go pulsed while busy is ignored; reset during RUN cycle 2 gives C_start=0 in the same cycle, busy=0, and no done.

Source files
------------

// File: rtl/auction_round_sequencer.sv
// auction_round_sequencer
//   Drives one configure-and-run cycle of an external auction unit. The
//   block writes the configuration opcodes in order, locks the unit, waits
//   for it to report ready, holds the round-start level for round_len
//   cycles, and then waits for the unit to report round-over. A done pulse
//   reports the outcome in status and result.
//
// Ports
//   clk, reset                 clock (rising edge), asynchronous active-high reset
//   go                         start request, accepted only in IDLE
//   cfg_key .. cfg_charge      configuration words, captured when go is accepted
//   round_len                  number of cycles C_start is held high (0 acts as 1)
//   busy, done                 sequence in progress / one-cycle completion pulse
//   status                     0=OK 1=CFG_ERR 2=READY_TIMEOUT 3=OVER_TIMEOUT
//   result                     maxBid captured at round end
//   C_op, C_data, C_start      command bus to the auction unit
//   ready, err, roundOver      status from the auction unit
//   maxBid                     winning bid from the auction unit
module auction_round_sequencer #(
  parameter int DATAWIDTH = 32,
  parameter int RLENW     = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 go,
  input  logic [DATAWIDTH-1:0] cfg_key,
  input  logic [DATAWIDTH-1:0] cfg_x,
  input  logic [DATAWIDTH-1:0] cfg_y,
  input  logic [DATAWIDTH-1:0] cfg_z,
  input  logic [DATAWIDTH-1:0] cfg_mask,
  input  logic [DATAWIDTH-1:0] cfg_timer,
  input  logic [DATAWIDTH-1:0] cfg_charge,
  input  logic [RLENW-1:0]     round_len,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           status,
  output logic [DATAWIDTH-1:0] result,
  output logic [3:0]           C_op,
  output logic [DATAWIDTH-1:0] C_data,
  output logic                 C_start,
  input  logic                 ready,
  input  logic [3:0]           err,
  input  logic                 roundOver,
  input  logic [DATAWIDTH-1:0] maxBid
);

  // Wait counter is wide enough to hold TIMEOUT itself so it can saturate.
  localparam int WCW = $clog2(TIMEOUT + 1);

  localparam logic [3:0] OP_NO_OP        = 4'd0;
  localparam logic [3:0] OP_UNLOCK       = 4'd1;
  localparam logic [3:0] OP_LOCK         = 4'd2;
  localparam logic [3:0] OP_LOADX        = 4'd3;
  localparam logic [3:0] OP_LOADY        = 4'd4;
  localparam logic [3:0] OP_LOADZ        = 4'd5;
  localparam logic [3:0] OP_SETMASK      = 4'd6;
  localparam logic [3:0] OP_SETTIMER     = 4'd7;
  localparam logic [3:0] OP_SETBIDCHARGE = 4'd8;

  localparam logic [2:0] ST_OK            = 3'd0;
  localparam logic [2:0] ST_CFG_ERR       = 3'd1;
  localparam logic [2:0] ST_READY_TIMEOUT = 3'd2;
  localparam logic [2:0] ST_OVER_TIMEOUT  = 3'd3;

  typedef enum logic [3:0] {
    IDLE, UNLK, LDX, LDY, LDZ, MASK, TMR, CHG, LOCK,
    WAIT_READY, RUN, WAIT_OVER, FIN
  } state_t;

  state_t               state_reg, state_next;
  logic [DATAWIDTH-1:0] key_reg, x_reg, y_reg, z_reg, mask_reg, timer_reg, charge_reg;
  logic [RLENW-1:0]     rlen_reg;
  logic [RLENW-1:0]     run_cnt_reg, run_cnt_next;
  logic [WCW-1:0]       wait_cnt_reg, wait_cnt_next, wait_cnt_inc;
  logic                 wait_expired;
  logic [2:0]           status_reg, status_next;
  logic [DATAWIDTH-1:0] result_reg, result_next;
  logic                 load_cfg;

  logic [3:0]           c_op_reg, op_next;
  logic [DATAWIDTH-1:0] c_data_reg, data_next;
  logic                 c_start_reg, busy_reg, done_reg;

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign status  = status_reg;
  assign result  = result_reg;
  assign C_op    = c_op_reg;
  assign C_data  = c_data_reg;
  assign C_start = c_start_reg;

  // The current wait cycle is the last allowed one once TIMEOUT-1 earlier
  // cycles have been seen without the awaited signal.
  assign wait_expired = (wait_cnt_reg >= WCW'(TIMEOUT - 1));
  assign wait_cnt_inc = (wait_cnt_reg == WCW'(TIMEOUT)) ? wait_cnt_reg
                                                        : wait_cnt_reg + 1'b1;

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    run_cnt_next  = run_cnt_reg;
    status_next   = status_reg;
    result_next   = result_reg;
    load_cfg      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (go) begin
          load_cfg    = 1'b1;
          status_next = ST_OK;
          state_next  = UNLK;
        end
      end
      UNLK, LDX, LDY, LDZ, MASK, TMR, CHG, LOCK: begin
        if (err != 4'd0) begin
          status_next = ST_CFG_ERR;
          state_next  = FIN;
        end else begin
          case (state_reg)
            UNLK:    state_next = LDX;
            LDX:     state_next = LDY;
            LDY:     state_next = LDZ;
            LDZ:     state_next = MASK;
            MASK:    state_next = TMR;
            TMR:     state_next = CHG;
            CHG:     state_next = LOCK;
            LOCK: begin
              state_next    = WAIT_READY;
              wait_cnt_next = '0;
            end
            default: state_next = IDLE;
          endcase
        end
      end
      WAIT_READY: begin
        if (ready) begin
          state_next   = RUN;
          // A zero length still produces a one-cycle start pulse.
          run_cnt_next = (rlen_reg == '0) ? RLENW'(1) : rlen_reg;
        end else if (wait_expired) begin
          status_next = ST_READY_TIMEOUT;
          state_next  = FIN;
        end else begin
          wait_cnt_next = wait_cnt_inc;
        end
      end
      RUN: begin
        // roundOver is deliberately not looked at here.
        if (run_cnt_reg <= RLENW'(1)) begin
          state_next    = WAIT_OVER;
          wait_cnt_next = '0;
        end else begin
          run_cnt_next = run_cnt_reg - 1'b1;
        end
      end
      WAIT_OVER: begin
        if (roundOver) begin
          result_next = maxBid;
          status_next = ST_OK;
          state_next  = FIN;
        end else if (wait_expired) begin
          status_next = ST_OVER_TIMEOUT;
          state_next  = FIN;
        end else begin
          wait_cnt_next = wait_cnt_inc;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Command bus contents for the state about to be entered. UNLK is only
  // entered from IDLE on the edge that captures the configuration, so it
  // takes the key straight from the input.
  always_comb begin
    op_next   = OP_NO_OP;
    data_next = '0;
    case (state_next)
      UNLK: begin op_next = OP_UNLOCK;       data_next = cfg_key;    end
      LDX:  begin op_next = OP_LOADX;        data_next = x_reg;      end
      LDY:  begin op_next = OP_LOADY;        data_next = y_reg;      end
      LDZ:  begin op_next = OP_LOADZ;        data_next = z_reg;      end
      MASK: begin op_next = OP_SETMASK;      data_next = mask_reg;   end
      TMR:  begin op_next = OP_SETTIMER;     data_next = timer_reg;  end
      CHG:  begin op_next = OP_SETBIDCHARGE; data_next = charge_reg; end
      LOCK: begin op_next = OP_LOCK;         data_next = key_reg;    end
      default: begin op_next = OP_NO_OP;     data_next = '0;         end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      key_reg      <= '0;
      x_reg        <= '0;
      y_reg        <= '0;
      z_reg        <= '0;
      mask_reg     <= '0;
      timer_reg    <= '0;
      charge_reg   <= '0;
      rlen_reg     <= '0;
      run_cnt_reg  <= '0;
      wait_cnt_reg <= '0;
      status_reg   <= ST_OK;
      result_reg   <= '0;
      c_op_reg     <= OP_NO_OP;
      c_data_reg   <= '0;
      c_start_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      run_cnt_reg  <= run_cnt_next;
      wait_cnt_reg <= wait_cnt_next;
      status_reg   <= status_next;
      result_reg   <= result_next;
      if (load_cfg) begin
        key_reg    <= cfg_key;
        x_reg      <= cfg_x;
        y_reg      <= cfg_y;
        z_reg      <= cfg_z;
        mask_reg   <= cfg_mask;
        timer_reg  <= cfg_timer;
        charge_reg <= cfg_charge;
        rlen_reg   <= round_len;
      end
      // Outputs are registered alongside the state they belong to.
      c_op_reg    <= op_next;
      c_data_reg  <= data_next;
      c_start_reg <= (state_next == RUN);
      busy_reg    <= (state_next != IDLE);
      done_reg    <= (state_next == FIN);
    end
  end

endmodule

// File: tb/tb_auction_round_sequencer.sv
// Testbench for auction_round_sequencer: directed scenarios plus randomized
// transactions, each predicted from a cycle timeline computed per run.
module tb_auction_round_sequencer;
  localparam int DW = 32;
  localparam int RW = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          go;
  logic [DW-1:0] cfg_key, cfg_x, cfg_y, cfg_z, cfg_mask, cfg_timer, cfg_charge;
  logic [RW-1:0] round_len;
  logic          busy, done;
  logic [2:0]    status;
  logic [DW-1:0] result;
  logic [3:0]    C_op;
  logic [DW-1:0] C_data;
  logic          C_start;
  logic          ready;
  logic [3:0]    err;
  logic          roundOver;
  logic [DW-1:0] maxBid;

  int            checks = 0;
  int            errors = 0;
  int            txn_num = 0;
  logic [DW-1:0] exp_result = '0;

  auction_round_sequencer #(.DATAWIDTH(DW), .RLENW(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .go(go),
    .cfg_key(cfg_key), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_z(cfg_z),
    .cfg_mask(cfg_mask), .cfg_timer(cfg_timer), .cfg_charge(cfg_charge),
    .round_len(round_len), .busy(busy), .done(done), .status(status),
    .result(result), .C_op(C_op), .C_data(C_data), .C_start(C_start),
    .ready(ready), .err(err), .roundOver(roundOver), .maxBid(maxBid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string where);
    check({where, "_busy"}, 64'(busy), 64'd0);
    check({where, "_done"}, 64'(done), 64'd0);
    check({where, "_start"}, 64'(C_start), 64'd0);
    check({where, "_op"}, 64'(C_op), 64'd0);
    check({where, "_data"}, 64'(C_data), 64'd0);
  endtask

  // One complete transaction. e = config stage that reports err (8 = none),
  // d = cycles until ready, r = cycles into WAIT_OVER until roundOver,
  // d or r >= TO means the signal never arrives in time. abort_k > 0 asserts
  // reset in that cycle. Cycle 0 is the IDLE cycle in which go is driven.
  task automatic run_txn(input int e, input int d, input int r, input int rl,
                         input int abort_k, input bit nominal);
    logic [DW-1:0] cfg_words [8];
    logic [3:0]    ops [8];
    int            len, w, fin, st;
    logic [DW-1:0] prev_res, new_res;
    logic [63:0]   op_e, data_e;
    bit            in_cfg;

    ops = '{4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd2};
    len = (rl == 0) ? 1 : rl;
    w   = 10 + d + len;
    if (e < 8) begin
      fin = 2 + e; st = 1;
    end else if (d >= TO) begin
      fin = 9 + TO; st = 2;
    end else if (r >= TO) begin
      fin = w + TO; st = 3;
    end else begin
      fin = w + r + 1; st = 0;
    end
    prev_res = exp_result;
    new_res  = exp_result;

    for (int k = 0; k <= fin + 1; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        in_cfg = (k <= 8) && (k <= e + 1);
        op_e   = in_cfg ? 64'(ops[k-1]) : 64'd0;
        data_e = in_cfg ? 64'(cfg_words[k-1]) : 64'd0;
        check($sformatf("op@%0d", k), 64'(C_op), op_e);
        check($sformatf("data@%0d", k), 64'(C_data), data_e);
        check($sformatf("start@%0d", k), 64'(C_start),
              64'((e == 8) && (d < TO) && (k >= 10 + d) && (k <= 9 + d + len)));
        check($sformatf("busy@%0d", k), 64'(busy), 64'(k <= fin));
        check($sformatf("done@%0d", k), 64'(done), 64'(k == fin));
        check($sformatf("status@%0d", k), 64'(status), (k >= fin) ? 64'(st) : 64'd0);
        check($sformatf("result@%0d", k), 64'(result),
              (k >= fin) ? 64'(new_res) : 64'(prev_res));
        if (k == abort_k) begin
          reset = 1'b1;
          go = 1'b0; ready = 1'b0; err = 4'd0; roundOver = 1'b0;
          #1;
          check("rst_now_start", 64'(C_start), 64'd0);
          check("rst_now_busy", 64'(busy), 64'd0);
          check("rst_now_done", 64'(done), 64'd0);
          check("rst_now_status", 64'(status), 64'd0);
          check("rst_now_result", 64'(result), 64'd0);
          @(posedge clk); #1;
          check_quiet("rst_hold");
          exp_result = '0;
          $display("txn %0d aborted by reset in cycle %0d", txn_num, k);
          txn_num++;
          return;
        end
      end
      // Inputs for cycle k, sampled at the following edge.
      cfg_key = $urandom; cfg_x = $urandom; cfg_y = $urandom; cfg_z = $urandom;
      cfg_mask = $urandom; cfg_timer = $urandom; cfg_charge = $urandom;
      round_len = RW'($urandom_range(0, 9));
      maxBid = nominal ? DW'(42) : DW'($urandom);
      if (k == 0) begin
        if (nominal) begin
          cfg_key = 'hA5; cfg_x = 100; cfg_y = 50; cfg_z = 20;
          cfg_mask = 'b111; cfg_timer = 'hF; cfg_charge = 1;
        end
        round_len = RW'(rl);
        cfg_words = '{cfg_key, cfg_x, cfg_y, cfg_z, cfg_mask, cfg_timer, cfg_charge, cfg_key};
        go = 1'b1;
      end else begin
        go = (k <= fin) && ($urandom_range(0, 3) == 0);
      end
      // err: clean up to the failing stage, noise everywhere it is ignored.
      if (k >= 1 && k <= 8 && k <= e + 1)
        err = (k == e + 1) ? 4'($urandom_range(1, 15)) : 4'd0;
      else
        err = 4'($urandom_range(0, 15));
      if (e == 8 && k >= 9 && k <= 9 + ((d < TO) ? d : TO - 1))
        ready = (k == 9 + d);
      else
        ready = 1'($urandom_range(0, 1));
      if (e == 8 && d < TO && k >= w && k <= w + ((r < TO) ? r : TO - 1))
        roundOver = (k == w + r);
      else
        roundOver = 1'($urandom_range(0, 1));
      if (e == 8 && d < TO && r < TO && k == w + r)
        new_res = maxBid;
      if (k == fin + 1)
        go = 1'b0;
    end
    exp_result = new_res;
    $display("txn %0d err_stage=%0d ready_dly=%0d over_dly=%0d round_len=%0d -> status=%0d result=%0h",
             txn_num, e, d, r, rl, st, new_res);
    txn_num++;
  endtask

  initial begin
    reset = 1'b1; go = 1'b0; ready = 1'b0; err = 4'd0; roundOver = 1'b0;
    cfg_key = '0; cfg_x = '0; cfg_y = '0; cfg_z = '0;
    cfg_mask = '0; cfg_timer = '0; cfg_charge = '0; round_len = '0; maxBid = '0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    check("reset_status", 64'(status), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check_quiet("post_reset");

    run_txn(8, 2, 3, 4, 0, 1'b1);        // nominal run
    run_txn(2, 0, 0, 4, 0, 1'b0);        // err while in LDY
    run_txn(8, TO + 5, 0, 3, 0, 1'b0);   // ready timeout
    run_txn(8, 1, TO + 5, 2, 0, 1'b0);   // over timeout keeps previous result
    run_txn(8, 0, 1, 0, 0, 1'b0);        // round_len of zero
    run_txn(7, 0, 0, 1, 0, 1'b0);        // err in LOCK
    for (int i = 0; i < 40; i++) begin
      int e, d, r, rl;
      e  = ($urandom_range(0, 9) < 6) ? 8 : int'($urandom_range(0, 7));
      d  = int'($urandom_range(0, TO + 2));
      r  = int'($urandom_range(0, TO + 2));
      rl = int'($urandom_range(0, 6));
      run_txn(e, d, r, rl, 0, 1'b0);
    end

    // Reset during the second RUN cycle (ready immediately, RUN from cycle 10).
    run_txn(8, 0, 2, 5, 11, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_quiet("after_abort");
    end
    run_txn(8, 3, 2, 2, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
